tdes_round_ctrl: RTL and testbench

- Sequencer for the iterative Triple-DES datapath (E/P-box, the eight S-boxes, key schedule registers).
- Drives one Feistel round per cycle and steps three DES stages in E-D-E order (encrypt) or D-E-D order (decrypt).
- Tells the key schedule which subkey source to load and how to rotate it.
- Presents a start/done/ack handshake to the I2C-side control logic.

---
 rtl/tdes_round_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tdes_round_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdes_round_ctrl.sv
// Round/stage sequencer for an iterative Triple-DES datapath: one Feistel round per
// cycle, three DES stages in E-D-E (encrypt) or D-E-D (decrypt) order, start/done/ack handshake.
module tdes_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int NUM_STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic [1:0] stage,
    output logic [3:0] round,
    output logic [1:0] key_sel,
    output logic       stage_dir,
    output logic       load_data,
    output logic       src_sel,
    output logic       load_key,
    output logic       round_en,
    output logic       shift_en,
    output logic [1:0] shift_amt,
    output logic       shift_dir,
    output logic       last_round,
    output logic       fp_en
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ROUND     = 3'd2,
        STAGE_END = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] stage_q;
    logic [3:0] round_q;
    logic       mode_q;

    logic [1:0] stage_key;
    logic       stage_is_dec;
    logic       single_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = LOAD;
            LOAD:      state_nxt = ROUND;
            ROUND:     if (round_q == LAST_ROUND) state_nxt = STAGE_END;
            STAGE_END: state_nxt = (stage_q == LAST_STAGE) ? DONE : LOAD;
            DONE:      if (ack) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // round is cleared when leaving ROUND, so it reads 0 in every other state
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= 2'd0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stage_q <= 2'd0;
                        mode_q  <= decrypt;
                    end
                end
                ROUND: begin
                    if (round_q == LAST_ROUND) begin
                        round_q <= 4'd0;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                STAGE_END: begin
                    if (stage_q != LAST_STAGE) begin
                        stage_q <= stage_q + 2'd1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        stage_q <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Encrypt mode runs K1/E, K2/D, K3/E; decrypt mode mirrors it as K3/D, K2/E, K1/D
    assign stage_key    = mode_q ? (LAST_STAGE - stage_q) : stage_q;
    assign stage_is_dec = (stage_q == 2'd1) ^ mode_q;
    assign single_shift = (round_q == 4'd0) || (round_q == 4'd1) ||
                          (round_q == 4'd8) || (round_q == LAST_ROUND);

    assign stage = stage_q;
    assign round = round_q;

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        key_sel    = 2'd0;
        stage_dir  = 1'b0;
        load_data  = 1'b0;
        src_sel    = 1'b0;
        load_key   = 1'b0;
        round_en   = 1'b0;
        shift_en   = 1'b0;
        shift_amt  = 2'd0;
        shift_dir  = 1'b0;
        last_round = 1'b0;
        fp_en      = 1'b0;
        case (state)
            LOAD: begin
                busy      = 1'b1;
                key_sel   = stage_key;
                stage_dir = stage_is_dec;
                load_data = 1'b1;
                load_key  = 1'b1;
                src_sel   = (stage_q != 2'd0);
            end
            ROUND: begin
                busy       = 1'b1;
                key_sel    = stage_key;
                stage_dir  = stage_is_dec;
                round_en   = 1'b1;
                shift_en   = 1'b1;
                shift_dir  = stage_is_dec;
                last_round = (round_q == LAST_ROUND);
                // Decrypt skips the first rotation since PC-1 already yields K16's C/D
                if (stage_is_dec && round_q == 4'd0) begin
                    shift_amt = 2'd0;
                end else begin
                    shift_amt = single_shift ? 2'd1 : 2'd2;
                end
            end
            STAGE_END: begin
                busy      = 1'b1;
                key_sel   = stage_key;
                stage_dir = stage_is_dec;
                fp_en     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Self-checking bench for tdes_round_ctrl: per-cycle expected output words built from
// stage/rotation tables, queued at start and compared as the block runs.
module tb_tdes_round_ctrl;

    localparam int W = 21;

    logic       clk;
    logic       rst;
    logic       start;
    logic       decrypt;
    logic       ack;
    logic       busy;
    logic       done;
    logic [1:0] stage;
    logic [3:0] round;
    logic [1:0] key_sel;
    logic       stage_dir;
    logic       load_data;
    logic       src_sel;
    logic       load_key;
    logic       round_en;
    logic       shift_en;
    logic [1:0] shift_amt;
    logic       shift_dir;
    logic       last_round;
    logic       fp_en;

    int errors;
    int checks;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];

    // Output word layout: busy done stage round key_sel stage_dir load_data src_sel
    // load_key round_en shift_en shift_amt shift_dir last_round fp_en
    localparam logic [W-1:0] M_ALL   = {W{1'b1}};
    localparam logic [W-1:0] M_LOAD  = ~21'h00001C;
    localparam logic [W-1:0] M_ROUND = ~21'h000100;
    localparam logic [W-1:0] M_END   = ~21'h00011C;
    localparam logic [W-1:0] M_DONE  = ~21'h001D1C;

    typedef struct {
        logic       mode;
        logic [1:0] stg;
        logic [1:0] key;
        logic       dir;
    } map_t;

    map_t map_tab[6];
    int   enc_amt[16];
    int   dec_amt[16];

    tdes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .decrypt    (decrypt),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .stage      (stage),
        .round      (round),
        .key_sel    (key_sel),
        .stage_dir  (stage_dir),
        .load_data  (load_data),
        .src_sel    (src_sel),
        .load_key   (load_key),
        .round_en   (round_en),
        .shift_en   (shift_en),
        .shift_amt  (shift_amt),
        .shift_dir  (shift_dir),
        .last_round (last_round),
        .fp_en      (fp_en)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(
        input logic b, input logic d, input logic [1:0] s, input logic [3:0] r,
        input logic [1:0] k, input logic sd, input logic ld, input logic src,
        input logic lk, input logic ren, input logic sen, input logic [1:0] amt,
        input logic sdir, input logic last, input logic fp);
        return {b, d, s, r, k, sd, ld, src, lk, ren, sen, amt, sdir, last, fp};
    endfunction

    function automatic logic [W-1:0] actual();
        return {busy, done, stage, round, key_sel, stage_dir, load_data, src_sel,
                load_key, round_en, shift_en, shift_amt, shift_dir, last_round, fp_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp, input logic [W-1:0] mask);
        checks++;
        if (((act ^ exp) & mask) != '0) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: expected trace of one whole block, LOAD of stage 0 through DONE
    task automatic push_block(input logic mode);
        logic [1:0] k;
        logic       dr;
        logic [1:0] amt;
        for (int s = 0; s < 3; s++) begin
            k  = 2'd0;
            dr = 1'b0;
            for (int m = 0; m < 6; m++) begin
                if (map_tab[m].mode == mode && map_tab[m].stg == 2'(s)) begin
                    k  = map_tab[m].key;
                    dr = map_tab[m].dir;
                end
            end
            exp_q.push_back(mk(1, 0, 2'(s), 0, k, dr, 1, (s != 0), 1, 0, 0, 0, 0, 0, 0));
            mask_q.push_back(M_LOAD);
            for (int r = 0; r < 16; r++) begin
                amt = dr ? 2'(dec_amt[r]) : 2'(enc_amt[r]);
                exp_q.push_back(mk(1, 0, 2'(s), 4'(r), k, dr, 0, 0, 0, 1, 1, amt, dr,
                                   (r == 15), 0));
                mask_q.push_back(M_ROUND);
            end
            exp_q.push_back(mk(1, 0, 2'(s), 0, k, dr, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            mask_q.push_back(M_END);
        end
        exp_q.push_back(mk(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mask_q.push_back(M_DONE);
    endtask

    // driver: start accepted at the next edge, which leaves the DUT in LOAD
    task automatic start_block(input logic mode);
        start   = 1'b1;
        decrypt = mode;
        push_block(mode);
        tick();
        start   = 1'b0;
        decrypt = 1'b0;
    endtask

    // Compares 55 cycles (54 busy + DONE); disturb injects ignored start/ack/decrypt
    // activity, abort_at asserts rst after that cycle index
    task automatic follow_block(input string tag, input bit disturb, input int abort_at);
        int n_fp, n_ld, n_ren, n_last;
        logic [W-1:0] e, m;
        n_fp = 0; n_ld = 0; n_ren = 0; n_last = 0;
        for (int i = 0; i < 55; i++) begin
            if (exp_q.size() == 0) begin
                chk_int({tag, "_queue_empty"}, 0, 1);
                break;
            end
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            chk($sformatf("%s_cyc%0d", tag, i), actual(), e, m);
            n_fp   += int'(fp_en);
            n_ld   += int'(load_data);
            n_ren  += int'(round_en);
            n_last += int'(last_round);
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk({tag, "_abort_zero"}, actual(), '0, M_ALL);
                exp_q.delete();
                mask_q.delete();
                return;
            end
            if (i == 54) break;
            if (disturb) begin
                start   = (i == 10) || (i == 40);
                ack     = (i == 20);
                decrypt = i[0];
            end
            tick();
        end
        start   = 1'b0;
        ack     = 1'b0;
        decrypt = 1'b0;
        chk_int({tag, "_fp_cnt"}, n_fp, 3);
        chk_int({tag, "_ld_cnt"}, n_ld, 3);
        chk_int({tag, "_ren_cnt"}, n_ren, 48);
        chk_int({tag, "_last_cnt"}, n_last, 3);
    endtask

    task automatic ack_done(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_idle"}, actual(), '0, M_ALL);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        map_tab[0] = '{mode: 1'b0, stg: 2'd0, key: 2'd0, dir: 1'b0};
        map_tab[1] = '{mode: 1'b0, stg: 2'd1, key: 2'd1, dir: 1'b1};
        map_tab[2] = '{mode: 1'b0, stg: 2'd2, key: 2'd2, dir: 1'b0};
        map_tab[3] = '{mode: 1'b1, stg: 2'd0, key: 2'd2, dir: 1'b1};
        map_tab[4] = '{mode: 1'b1, stg: 2'd1, key: 2'd1, dir: 1'b0};
        map_tab[5] = '{mode: 1'b1, stg: 2'd2, key: 2'd0, dir: 1'b1};
        enc_amt = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        dec_amt = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

        rst = 1'b1; start = 1'b0; decrypt = 1'b0; ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_zero", actual(), '0, M_ALL);

        // idle with ack and random decrypt but no start stays idle
        for (int i = 0; i < 4; i++) begin
            ack     = 1'(i % 2);
            decrypt = 1'($urandom_range(0, 1));
            tick();
            chk("idle_hold", actual(), '0, M_ALL);
        end
        ack = 1'b0;

        // plain encrypt and decrypt blocks
        start_block(1'b0);
        follow_block("enc", 1'b0, -1);
        ack_done("enc");
        start_block(1'b1);
        follow_block("dec", 1'b0, -1);
        ack_done("dec");

        // ignored start/ack/decrypt activity during an encrypt block
        start_block(1'b0);
        follow_block("disturb", 1'b1, -1);
        ack_done("disturb");

        // reset at round 7 of stage 1 (cycle 18 is stage 1 LOAD), then fresh start
        start_block(1'b1);
        follow_block("abort", 1'b0, 26);
        tick();
        chk("abort_stays_idle", actual(), '0, M_ALL);
        start_block(1'b0);
        follow_block("restart", 1'b0, -1);

        // start and ack together in DONE: start is dropped
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        chk("start_ack_idle", actual(), '0, M_ALL);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("start_ack_stay", actual(), '0, M_ALL);
        end

        // start held through ack: block begins one cycle after IDLE
        start_block(1'b1);
        follow_block("held_pre", 1'b0, -1);
        start = 1'b1;
        ack   = 1'b1;
        tick();
        ack = 1'b0;
        chk("held_idle", actual(), '0, M_ALL);
        push_block(1'b0);
        tick();
        start = 1'b0;
        follow_block("held", 1'b0, -1);
        ack_done("held");

        chk_int("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
